// File: rtl/sw_stream_driver.sv
// sw_stream_driver: host-side transmitter for the Smith-Waterman core.
// Buffers one reference and one query sequence, streams them to the core as
// a single valid burst, waits for the core's finish pulse (with a watchdog),
// and presents the captured result to the host with a one-cycle done pulse.
module sw_stream_driver #(
    parameter int REF_LEN         = 64,
    parameter int QUERY_LEN       = 48,
    parameter int WIDTH_SCORE     = 8,
    parameter int WIDTH_POS_REF   = 7,
    parameter int WIDTH_POS_QUERY = 6,
    parameter int TIMEOUT         = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [5:0]                 wr_addr,
    input  logic [1:0]                 wr_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [WIDTH_SCORE-1:0]     res_max,
    output logic [WIDTH_POS_REF-1:0]   res_pos_ref,
    output logic [WIDTH_POS_QUERY-1:0] res_pos_query,
    output logic                       sw_valid,
    output logic [1:0]                 sw_data_ref,
    output logic [1:0]                 sw_data_query,
    input  logic                       sw_finish,
    input  logic [WIDTH_SCORE-1:0]     sw_max,
    input  logic [WIDTH_POS_REF-1:0]   sw_pos_ref,
    input  logic [WIDTH_POS_QUERY-1:0] sw_pos_query
);

    localparam int BW = $clog2(REF_LEN);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    state_t                     r_state, w_state_nxt;
    logic [BW-1:0]              r_beat, w_beat_nxt, w_beat_inc;
    logic [WW-1:0]              r_wait, w_wait_nxt;
    logic                       r_busy, w_busy_nxt;
    logic                       r_done, w_done_nxt;
    logic                       r_timeout, w_timeout_nxt;
    logic [WIDTH_SCORE-1:0]     r_max, w_max_nxt;
    logic [WIDTH_POS_REF-1:0]   r_pref, w_pref_nxt;
    logic [WIDTH_POS_QUERY-1:0] r_pq, w_pq_nxt;
    logic                       r_valid, w_valid_nxt;
    logic [1:0]                 r_dref, w_dref_nxt;
    logic [1:0]                 r_dq, w_dq_nxt;

    // Sequence buffers are deliberately left uncleared by reset.
    logic [1:0] r_ref   [REF_LEN];
    logic [1:0] r_query [QUERY_LEN];

    assign w_beat_inc = r_beat + BW'(1);

    // Host writes land only while idle and only inside each buffer's range.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && wr_en) begin
            if (!wr_sel && int'(wr_addr) < REF_LEN)
                r_ref[wr_addr] <= wr_data;
            if (wr_sel && int'(wr_addr) < QUERY_LEN)
                r_query[wr_addr] <= wr_data;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        w_wait_nxt    = r_wait;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = r_timeout;
        w_max_nxt     = r_max;
        w_pref_nxt    = r_pref;
        w_pq_nxt      = r_pq;
        w_valid_nxt   = r_valid;
        w_dref_nxt    = r_dref;
        w_dq_nxt      = r_dq;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt   = S_SEND;
                    w_busy_nxt    = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_timeout_nxt = 1'b0;
                    w_beat_nxt    = '0;
                    w_dref_nxt    = r_ref[0];
                    w_dq_nxt      = r_query[0];
                end
            end
            S_SEND: begin
                if (r_beat == BW'(REF_LEN - 1)) begin
                    // Last beat has been on the bus for its cycle; close the burst.
                    w_state_nxt = S_WAIT;
                    w_valid_nxt = 1'b0;
                    w_dref_nxt  = 2'b00;
                    w_dq_nxt    = 2'b00;
                    w_wait_nxt  = '0;
                end else begin
                    w_beat_nxt = w_beat_inc;
                    w_dref_nxt = r_ref[w_beat_inc];
                    // Reference is longer than the query; pad the tail with zeros.
                    w_dq_nxt   = (int'(w_beat_inc) < QUERY_LEN) ? r_query[w_beat_inc] : 2'b00;
                end
            end
            S_WAIT: begin
                // A finish on the watchdog's final edge still counts as a result.
                if (sw_finish) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_max_nxt   = sw_max;
                    w_pref_nxt  = sw_pos_ref;
                    w_pq_nxt    = sw_pos_query;
                end else if (r_wait == WW'(TIMEOUT)) begin
                    w_state_nxt   = S_DONE;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_max_nxt     = '0;
                    w_pref_nxt    = '0;
                    w_pq_nxt      = '0;
                end else begin
                    w_wait_nxt = r_wait + WW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any job with no partial result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            r_wait    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_max     <= '0;
            r_pref    <= '0;
            r_pq      <= '0;
            r_valid   <= 1'b0;
            r_dref    <= 2'b00;
            r_dq      <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            r_beat    <= w_beat_nxt;
            r_wait    <= w_wait_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_timeout <= w_timeout_nxt;
            r_max     <= w_max_nxt;
            r_pref    <= w_pref_nxt;
            r_pq      <= w_pq_nxt;
            r_valid   <= w_valid_nxt;
            r_dref    <= w_dref_nxt;
            r_dq      <= w_dq_nxt;
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign timeout       = r_timeout;
    assign res_max       = r_max;
    assign res_pos_ref   = r_pref;
    assign res_pos_query = r_pq;
    assign sw_valid      = r_valid;
    assign sw_data_ref   = r_dref;
    assign sw_data_query = r_dq;

endmodule

// File: tb/tb_sw_stream_driver.sv
// Scoreboard bench for sw_stream_driver: stimulus pushes expected beats,
// burst lengths and results; a negedge monitor pops and compares them.
module tb_sw_stream_driver;

    localparam int REF_LEN = 64;
    localparam int QUERY_LEN = 48;

    typedef struct {
        logic [1:0] r;
        logic [1:0] q;
    } beat_t;

    typedef struct {
        logic [7:0] mx;
        logic [6:0] pr;
        logic [5:0] pq;
        logic       to;
    } res_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, wr_sel, start;
    logic [5:0] wr_addr;
    logic [1:0] wr_data;
    logic       busy, done, timeout;
    logic [7:0] res_max;
    logic [6:0] res_pos_ref;
    logic [5:0] res_pos_query;
    logic       sw_valid;
    logic [1:0] sw_data_ref, sw_data_query;
    logic       sw_finish;
    logic [7:0] sw_max;
    logic [6:0] sw_pos_ref;
    logic [5:0] sw_pos_query;

    always #5 clk = ~clk;

    sw_stream_driver dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .timeout(timeout),
        .res_max(res_max), .res_pos_ref(res_pos_ref), .res_pos_query(res_pos_query),
        .sw_valid(sw_valid), .sw_data_ref(sw_data_ref), .sw_data_query(sw_data_query),
        .sw_finish(sw_finish), .sw_max(sw_max), .sw_pos_ref(sw_pos_ref),
        .sw_pos_query(sw_pos_query)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t exp_beats[$];
    int    exp_len[$];
    res_t  exp_res[$];
    logic [1:0] m_ref [REF_LEN];
    logic [1:0] m_q   [QUERY_LEN];
    int    run_len = 0;
    logic  prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Idle-time write; the bench model applies the same range rule.
    task automatic wr(input logic sel, input int addr, input logic [1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 6'(addr); wr_data = d;
        if (!sel && addr < REF_LEN) m_ref[addr] = d;
        if (sel && addr < QUERY_LEN) m_q[addr] = d;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic start_job;
        beat_t b;
        for (int k = 0; k < REF_LEN; k++) begin
            b.r = m_ref[k];
            b.q = (k < QUERY_LEN) ? m_q[k] : 2'b00;
            exp_beats.push_back(b);
        end
        exp_len.push_back(REF_LEN);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_valid", 32'(sw_valid), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_timeout_clr", 32'(timeout), 32'd0);
    endtask

    task automatic finish_after(input int n, input logic [7:0] mx, input logic [6:0] pr, input logic [5:0] pq);
        res_t e;
        repeat (n) tick;
        e.mx = mx; e.pr = pr; e.pq = pq; e.to = 1'b0;
        exp_res.push_back(e);
        sw_finish = 1'b1; sw_max = mx; sw_pos_ref = pr; sw_pos_query = pq;
        tick;
        sw_finish = 1'b0; sw_max = '0; sw_pos_ref = '0; sw_pos_query = '0;
        chk("done_after_finish", 32'(done), 32'd1);
        tick;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("res_hold", 32'(res_max), 32'(mx));
    endtask

    // Monitor: beats, burst lengths and results are compared as the DUT shows them.
    always @(negedge clk) begin
        beat_t b;
        res_t  e;
        if (reset) begin
            run_len    = 0;
            prev_valid = 1'b0;
        end else begin
            if (sw_valid) begin
                if (exp_beats.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_unexpected: got ref=%0d query=%0d expected no beat", sw_data_ref, sw_data_query);
                end else begin
                    b = exp_beats.pop_front();
                    chk("beat", {27'd0, busy, sw_data_ref, sw_data_query}, {27'd0, 1'b1, b.r, b.q});
                end
                run_len++;
            end else if (prev_valid) begin
                if (exp_len.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL burst_unexpected: got length %0d expected no burst", run_len);
                end else begin
                    chk("burst_len", 32'(run_len), 32'(exp_len.pop_front()));
                end
                chk("data_after_burst", {28'd0, sw_data_ref, sw_data_query}, 32'd0);
                run_len = 0;
            end
            prev_valid = sw_valid;
            if (done) begin
                if (exp_res.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got done=1 expected 0");
                end else begin
                    e = exp_res.pop_front();
                    chk("result", {10'd0, timeout, res_max, res_pos_ref, res_pos_query},
                        {10'd0, e.to, e.mx, e.pr, e.pq});
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1);
    end

    initial begin
        int   k;
        res_t e;
        reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; sw_finish = 1'b0; sw_max = '0; sw_pos_ref = '0; sw_pos_query = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_valid", 32'(sw_valid), 32'd0);
        chk("rst_data", {28'd0, sw_data_ref, sw_data_query}, 32'd0);
        chk("rst_res", {11'd0, res_max, res_pos_ref, res_pos_query}, 32'd0);
        reset = 1'b0;
        tick;

        // Load ref[k]=k%4, query[k]=3-k%4; out-of-range query write is dropped.
        for (int i = 0; i < REF_LEN; i++) wr(1'b0, i, 2'(i % 4));
        for (int i = 0; i < QUERY_LEN; i++) wr(1'b1, i, 2'(3 - i % 4));
        wr(1'b1, 50, 2'd1);

        // Job 1: stray finish during SEND is ignored; mock core answers 150 cycles later.
        start_job;
        for (int i = 1; i <= REF_LEN; i++) begin
            sw_finish = (i == 10);
            sw_max = (i == 10) ? 8'd99 : 8'd0;
            tick;
        end
        sw_finish = 1'b0;
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_valid", 32'(sw_valid), 32'd0);
        finish_after(150, 8'd42, 7'd37, 6'd20);

        // Job 2: no finish -> watchdog ends the job 1024 cycles after WAIT entry.
        start_job;
        e.mx = 8'd0; e.pr = 7'd0; e.pq = 6'd0; e.to = 1'b1;
        exp_res.push_back(e);
        repeat (REF_LEN) tick;
        k = 0;
        while (!done && k < 1200) begin
            tick;
            k++;
        end
        chk("timeout_latency", 32'(k), 32'd1024);
        tick;
        chk("timeout_held", 32'(timeout), 32'd1);
        chk("timeout_busy", 32'(busy), 32'd0);

        // Job 3: write and restart while busy are both ignored.
        start_job;
        repeat (5) tick;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 6'd5; wr_data = 2'd0; start = 1'b1;
        tick;
        wr_en = 1'b0; start = 1'b0;
        repeat (REF_LEN - 6) tick;
        finish_after(3, 8'd200, 7'd100, 6'd47);

        // Job 4: change ref[63], then abort with reset at beat 20.
        wr(1'b0, 63, 2'd1);
        start_job;
        repeat (20) tick;
        reset = 1'b1;
        #1;
        chk("abort_valid", 32'(sw_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        exp_beats.delete();
        exp_len.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick;

        // Job 5: full fresh burst (ref[5] original, ref[63]=1); finish on the watchdog edge.
        start_job;
        repeat (REF_LEN) tick;
        repeat (1023) tick;
        chk("late_no_done", 32'(done), 32'd0);
        e.mx = 8'd77; e.pr = 7'd64; e.pq = 6'd33; e.to = 1'b0;
        exp_res.push_back(e);
        sw_finish = 1'b1; sw_max = 8'd77; sw_pos_ref = 7'd64; sw_pos_query = 6'd33;
        tick;
        sw_finish = 1'b0;
        chk("edge_finish_done", 32'(done), 32'd1);
        chk("edge_finish_no_to", 32'(timeout), 32'd0);
        tick;
        chk("edge_busy", 32'(busy), 32'd0);

        repeat (3) tick;
        chk("beats_left", 32'(exp_beats.size()), 32'd0);
        chk("lens_left", 32'(exp_len.size()), 32'd0);
        chk("results_left", 32'(exp_res.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sw_stream_driver.md
Name: sw_stream_driver

Overview:
- Host-side transmitter for the Smith-Waterman alignment core's serial input interface.
- Holds one reference sequence and one query sequence (2-bit nucleotide symbols) loaded over a simple write port.
- On start, streams both sequences to the core with a valid burst, then waits for the core's finish pulse.
- Captures max score and end positions and presents them to the host with a done pulse; includes a timeout watchdog.

Parameters:
REF_LEN, 64, reference symbols per job (beats of sw_valid)
QUERY_LEN, 48, query symbols per job; must be <= REF_LEN
WIDTH_SCORE, 8, width of captured score
WIDTH_POS_REF, 7, width of captured reference position
WIDTH_POS_QUERY, 6, width of captured query position
TIMEOUT, 1023, max cycles spent in WAIT before abort

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
wr_en  input  1  host write strobe to sequence buffers
wr_sel  input  1  0 = reference buffer, 1 = query buffer
wr_addr  input  6  symbol index
wr_data  input  2  symbol value
start  input  1  launch job; sampled in IDLE only
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when the job ends (result or timeout)
timeout  output  1  high with done and held until next start if the job timed out
res_max  output  WIDTH_SCORE  captured score
res_pos_ref  output  WIDTH_POS_REF  captured reference end position
res_pos_query  output  WIDTH_POS_QUERY  captured query end position
sw_valid  output  1  to core: input burst valid
sw_data_ref  output  2  to core: reference symbol
sw_data_query  output  2  to core: query symbol
sw_finish  input  1  from core: result valid, one-cycle pulse
sw_max  input  WIDTH_SCORE  from core
sw_pos_ref  input  WIDTH_POS_REF  from core
sw_pos_query  input  WIDTH_POS_QUERY  from core

Behaviour:
- Reset: state IDLE; all outputs 0; beat and wait counters 0; buffer contents are don't-care (not cleared).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Writes:
  - wr_en in IDLE writes wr_data to the buffer selected by wr_sel at wr_addr.
  - A query write with wr_addr >= QUERY_LEN, or a reference write with wr_addr >= REF_LEN, is ignored.
  - wr_en while busy=1 is ignored and leaves buffers unchanged.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE -> SEND: when start=1 at a clock edge.
  - At that edge: busy<=1, sw_valid<=1, beat 0 driven, timeout<=0.
  - start has no effect in any state other than IDLE.
- SEND:
  - sw_valid is high for exactly REF_LEN consecutive cycles, beats k = 0..REF_LEN-1.
  - sw_data_ref = ref[k].
  - sw_data_query = query[k] for k < QUERY_LEN, else 2'b00.
  - After beat REF_LEN-1: sw_valid<=0, both data outputs<=0, go to WAIT.
- WAIT:
  - The wait counter increments every cycle.
  - sw_finish=1: latch sw_max / sw_pos_ref / sw_pos_query into the res_* outputs at that edge, go to DONE.
  - Counter reaches TIMEOUT without sw_finish: res_* <= 0, timeout <= 1, go to DONE.
  - sw_finish on the same edge the counter hits TIMEOUT: finish wins, timeout stays 0.
- DONE: done=1 for exactly this one cycle, then go to IDLE; busy falls to 0 on the same edge done falls.
- res_* outputs hold their values until the next job completes.
- sw_finish outside WAIT is ignored.
- A start is accepted no earlier than the cycle after done, so sw_valid is low for at least 2 cycles between consecutive bursts.
- Asynchronous reset mid-job (any state) returns to IDLE immediately: sw_valid=0, done=0, busy=0; no partial result is presented.

Test Plan:
- Load ref[k]=k%4 and query[k]=(3-k%4) for all indices; start -> sw_valid high exactly 64 cycles, starting the cycle after start. Beat 0 carries ref=0/query=3, beat 47 carries ref=3/query=0, beats 48..63 carry query=0. busy=1 throughout.
- After the burst, a mock core pulses sw_finish 150 cycles later with sw_max=8'd42, sw_pos_ref=7'd37, sw_pos_query=6'd20 -> next cycle done=1, res_max=42, res_pos_ref=37, res_pos_query=20, timeout=0. busy=0 the cycle after.
- No sw_finish after the burst -> done pulses 1024 cycles after WAIT entry with timeout=1 and res_*=0. A following start clears timeout.
- During SEND, issue wr_en to ref[5] and a second start -> burst length and data unchanged; the next job still sends the original ref[5].
- Assert reset at beat 20 of SEND -> sw_valid=0 and busy=0 immediately. A fresh start then streams a full 64-beat burst from beat 0.
- Query write to wr_addr=50 is ignored -> query buffer unchanged; reference write to wr_addr=63 lands on beat 63.
